// File: rtl/vec_alu_sequencer.sv
// Lane-serial issue controller for the combinational scalar alu: latches one
// packed vector op, steps one lane per clock, and gathers results and flags.
module vec_alu_sequencer #(
    parameter int WIDTH = 3,
    parameter int LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   op_code,
    input  logic                         carry_in,
    input  logic [LANES*(WIDTH+1)-1:0]   vec_a,
    input  logic [LANES*(WIDTH+1)-1:0]   vec_b,
    output logic [WIDTH:0]               alu_a,
    output logic [WIDTH:0]               alu_b,
    output logic [1:0]                   alu_op,
    output logic                         alu_ci,
    input  logic [WIDTH:0]               alu_out,
    input  logic                         alu_cero,
    input  logic                         alu_negativo,
    output logic [LANES*(WIDTH+1)-1:0]   vec_out,
    output logic [LANES-1:0]             zero_mask,
    output logic [LANES-1:0]             neg_mask,
    output logic                         busy,
    output logic                         done
);
    localparam int EW    = WIDTH + 1;
    localparam int VW    = LANES * EW;
    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [VW-1:0]      r_a;
    logic [VW-1:0]      r_b;
    logic [1:0]         r_op;
    logic               r_ci;
    logic [VW-1:0]      r_vec_out;
    logic [LANES-1:0]   r_zero;
    logic [LANES-1:0]   r_neg;
    logic [WIDTH:0]     w_lane_a;
    logic [WIDTH:0]     w_lane_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                busy = 1'b1;
                if (r_idx == LAST_IDX) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lane select from the latched operands; alu sees zeros outside ISSUE.
    always_comb begin
        w_lane_a = '0;
        w_lane_b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_lane_a = r_a[i*EW +: EW];
                w_lane_b = r_b[i*EW +: EW];
            end
        end
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        alu_ci = 1'b0;
        if (r_state == S_ISSUE) begin
            alu_a  = w_lane_a;
            alu_b  = w_lane_b;
            alu_op = r_op;
            alu_ci = r_ci;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_ci      <= 1'b0;
            r_vec_out <= '0;
            r_zero    <= '0;
            r_neg     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a       <= vec_a;
                        r_b       <= vec_b;
                        r_op      <= op_code;
                        r_ci      <= carry_in;
                        r_vec_out <= '0;
                        r_zero    <= '0;
                        r_neg     <= '0;
                        r_idx     <= '0;
                    end
                end
                S_ISSUE: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_vec_out[i*EW +: EW] <= alu_out;
                            r_zero[i]             <= alu_cero;
                            r_neg[i]              <= alu_negativo;
                        end
                    end
                    r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign vec_out   = r_vec_out;
    assign zero_mask = r_zero;
    assign neg_mask  = r_neg;

endmodule

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
Issue-side controller for the scalar alu. It accepts a packed vector operation (two operand vectors, opcode, carry-in) and feeds one lane per clock to the alu's a/b/opCode/ci inputs. In the same cycle it captures the combinational out/cero/negativo response into a packed result vector and per-lane flag masks. It sits between the vector register file/decoder and the alu; the alu itself stays purely combinational.

Parameters:
WIDTH, 3, MSB index of one element (element width = WIDTH+1 bits, same meaning as alu WIDTH)
LANES, 4, number of elements per vector (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op_code  input  2  alu opcode (00 add, 01 mul, 10 div, 11 sub)
carry_in  input  1  ci applied to every lane
vec_a  input  LANES*(WIDTH+1)  operand A; lane i at bits [i*(WIDTH+1) +: WIDTH+1]
vec_b  input  LANES*(WIDTH+1)  operand B, same packing
alu_a  output  WIDTH+1  to alu a
alu_b  output  WIDTH+1  to alu b
alu_op  output  2  to alu opCode
alu_ci  output  1  to alu ci
alu_out  input  WIDTH+1  from alu out
alu_cero  input  1  from alu cero
alu_negativo  input  1  from alu negativo
vec_out  output  LANES*(WIDTH+1)  result vector, same packing
zero_mask  output  LANES  bit i = alu cero of lane i
neg_mask  output  LANES  bit i = alu negativo of lane i
busy  output  1  high in ISSUE
done  output  1  one-cycle pulse when results are valid

Behaviour:
- Reset (rst_n low, asynchronous, also mid-operation): state IDLE, lane index 0, latched operands/op/ci 0, vec_out 0, zero_mask 0, neg_mask 0, busy 0, done 0. alu_* outputs 0.
- FSM states IDLE, ISSUE, DONE.
- IDLE: busy=0, done=0. alu_a/alu_b/alu_op/alu_ci driven 0. On start=1 at a rising edge: latch vec_a, vec_b, op_code, carry_in; clear vec_out, zero_mask and neg_mask to 0; index=0; go to ISSUE.
- ISSUE: busy=1. Combinationally drive alu_a = latched A lane[index], alu_b = latched B lane[index], alu_op = latched op, alu_ci = latched ci. At each edge, write alu_out into vec_out lane[index], alu_cero into zero_mask[index], and alu_negativo into neg_mask[index]; increment index. At index==LANES-1 the capture edge moves to DONE and resets index to 0.
- DONE: done=1 for exactly one cycle, busy=0; vec_out and masks are final. Next state IDLE unconditionally. start is ignored in DONE.
- Latency: start accepted at edge k -> busy high cycles k+1..k+LANES -> done high in cycle k+LANES+1. Next start is accepted no earlier than the edge ending cycle k+LANES+2.
- start, vec_a, vec_b, op_code and carry_in changes while busy/done have no effect; operands are used only from the latched copies.
- vec_out and masks hold their values in IDLE until the next accepted start.
- Arithmetic is entirely the alu's: the add result wraps mod 2^(WIDTH+1), mul keeps the low WIDTH+1 bits, and a negative sub result is forced to 0 with cero=1, negativo=1. The sequencer does no arithmetic beyond index increment. The index register is $clog2(LANES) bits and never exceeds LANES-1.
- Divide by zero: the lane result is whatever the alu returns; no special handling is done.

Test Plan:
Add wrap (WIDTH=3, LANES=4, test alu attached): vec_a=16'h321F, vec_b=16'h1111, op=00, ci=0, start at edge k -> vec_out=16'h4320, zero_mask=4'b0001, neg_mask=4'b0000, done high only in cycle k+5, busy high cycles k+1..k+4.
Sub saturation: vec_a=16'h5132, vec_b=16'h2231, op=11, ci=0 -> vec_out=16'h3001, zero_mask=4'b0110, neg_mask=4'b0100.
Mul truncation: vec_a=16'h9321, vec_b=16'h2222, op=01 -> vec_out=16'h2642 (9*2=18 -> 2), zero_mask=0, neg_mask=0.
Start while busy: second start with different vec_a/op at cycle k+2 -> ignored; results match the first op; no second done pulse.
Reset mid-op: rst_n low during cycle k+2 -> busy, done, vec_out, masks and alu_* are 0 immediately; a fresh start after release completes normally in LANES+1 cycles.
Back-to-back: start held high continuously -> ops complete every LANES+2 cycles; each done is a single-cycle pulse.
